// File: rtl/day24_gate_sched.sv
// Gate-network sweep sequencer. It holds a programmable table of 2-input
// gates and a wire value/known store. It fires every gate whose inputs are
// resolved, one gate per cycle, and repeats until a full sweep makes no
// progress. It then reports the z-wire word or flags an unresolved error.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   gate_we/addr/op/a/b/y          gate table write (IDLE only)
//   wire_we/idx/val                prime a wire value, marks it known (IDLE only)
//   clear                          clear known bits, done, error (IDLE only)
//   start                          begin evaluation (IDLE only)
//   busy, done, error, sweeps, z_out  status and result
module day24_gate_sched #(
  parameter int unsigned NUM_WIRES = 64,
  parameter int unsigned WIRE_W    = 6,
  parameter int unsigned NUM_GATES = 32,
  parameter int unsigned GATE_W    = 5,
  parameter int unsigned Z_BASE    = 48,
  parameter int unsigned Z_BITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gate_we,
  input  logic [GATE_W-1:0] gate_addr,
  input  logic [1:0]        gate_op,
  input  logic [WIRE_W-1:0] gate_a,
  input  logic [WIRE_W-1:0] gate_b,
  input  logic [WIRE_W-1:0] gate_y,
  input  logic              wire_we,
  input  logic [WIRE_W-1:0] wire_idx,
  input  logic              wire_val,
  input  logic              clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        sweeps,
  output logic [Z_BITS-1:0] z_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EVAL   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_OFF = 2'b11;

  localparam logic [GATE_W-1:0] G_LAST = GATE_W'(NUM_GATES - 1);

  logic [1:0]           state_q, state_d;
  logic [GATE_W-1:0]    g_q, g_d;
  logic                 progress_q, progress_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [7:0]           sweeps_q, sweeps_d;
  logic [Z_BITS-1:0]    z_q, z_d;
  logic [NUM_WIRES-1:0] known_q, known_d;
  logic [NUM_WIRES-1:0] val_q, val_d;

  logic [1:0]           op_q [NUM_GATES];
  logic [WIRE_W-1:0]    a_q  [NUM_GATES];
  logic [WIRE_W-1:0]    b_q  [NUM_GATES];
  logic [WIRE_W-1:0]    y_q  [NUM_GATES];

  logic [1:0]           cur_op_c;
  logic [WIRE_W-1:0]    cur_a_c, cur_b_c, cur_y_c;
  logic                 fire_c;
  logic                 res_c;

  // Gate table: ops reset to disabled, wire fields need no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_GATES); i++) op_q[i] <= OP_OFF;
    end else if (gate_we && state_q == S_IDLE) begin
      op_q[gate_addr] <= gate_op;
    end
  end

  always_ff @(posedge clk) begin
    if (gate_we && state_q == S_IDLE) begin
      a_q[gate_addr] <= gate_a;
      b_q[gate_addr] <= gate_b;
      y_q[gate_addr] <= gate_y;
    end
  end

  // Current gate evaluation
  always_comb begin
    cur_op_c = op_q[g_q];
    cur_a_c  = a_q[g_q];
    cur_b_c  = b_q[g_q];
    cur_y_c  = y_q[g_q];
    fire_c   = (state_q == S_EVAL) && (cur_op_c != OP_OFF) &&
               known_q[cur_a_c] && known_q[cur_b_c] && !known_q[cur_y_c] &&
               (cur_y_c != cur_a_c) && (cur_y_c != cur_b_c);
    case (cur_op_c)
      OP_AND:  res_c = val_q[cur_a_c] & val_q[cur_b_c];
      OP_OR:   res_c = val_q[cur_a_c] | val_q[cur_b_c];
      OP_XOR:  res_c = val_q[cur_a_c] ^ val_q[cur_b_c];
      default: res_c = 1'b0;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      progress_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      sweeps_q   <= '0;
      z_q        <= '0;
      known_q    <= '0;
      val_q      <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      progress_q <= progress_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      sweeps_q   <= sweeps_d;
      z_q        <= z_d;
      known_q    <= known_d;
      val_q      <= val_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    progress_d = progress_q;
    done_d     = done_q;
    error_d    = error_q;
    sweeps_d   = sweeps_q;
    z_d        = z_q;
    known_d    = known_q;
    val_d      = val_q;
    case (state_q)
      S_IDLE: begin
        if (wire_we) begin
          val_d[wire_idx]   = wire_val;
          known_d[wire_idx] = 1'b1;
        end
        if (clear) begin
          known_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end else if (start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          z_d        = '0;
          sweeps_d   = '0;
          g_d        = '0;
          progress_d = 1'b0;
          state_d    = S_EVAL;
        end
      end
      S_EVAL: begin
        if (fire_c) begin
          val_d[cur_y_c]   = res_c;
          known_d[cur_y_c] = 1'b1;
        end
        if (g_q == G_LAST) begin
          sweeps_d = (sweeps_q == 8'hFF) ? sweeps_q : sweeps_q + 8'd1;
          if (progress_q || fire_c) begin
            g_d        = '0;
            progress_d = 1'b0;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          g_d        = g_q + GATE_W'(1);
          progress_d = progress_q | fire_c;
        end
      end
      S_FINISH: begin
        if (&known_q[Z_BASE +: Z_BITS]) begin
          done_d = 1'b1;
          z_d    = val_q[Z_BASE +: Z_BITS];
        end else begin
          error_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign sweeps = sweeps_q;
  assign z_out  = z_q;

endmodule

// File: tb/tb_day24_gate_sched.sv
// Directed bench for day24_gate_sched: immediate assertions against
// hand-computed expectations for each scenario.
module tb_day24_gate_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       gate_we;
  logic [4:0] gate_addr;
  logic [1:0] gate_op;
  logic [5:0] gate_a, gate_b, gate_y;
  logic       wire_we;
  logic [5:0] wire_idx;
  logic       wire_val;
  logic       clear;
  logic       start;
  logic       busy, done, error;
  logic [7:0] sweeps;
  logic [7:0] z_out;

  int errors = 0;
  int checks = 0;
  int n;

  day24_gate_sched dut (
    .clk(clk), .rst(rst),
    .gate_we(gate_we), .gate_addr(gate_addr), .gate_op(gate_op),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
    .wire_we(wire_we), .wire_idx(wire_idx), .wire_val(wire_val),
    .clear(clear), .start(start),
    .busy(busy), .done(done), .error(error), .sweeps(sweeps), .z_out(z_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_gate(input int addr, input logic [1:0] op, input int a, input int b, input int y);
    gate_we = 1'b1; gate_addr = 5'(addr); gate_op = op;
    gate_a = 6'(a); gate_b = 6'(b); gate_y = 6'(y);
    tick();
    gate_we = 1'b0;
  endtask

  task automatic prime(input int idx, input logic v);
    wire_we = 1'b1; wire_idx = 6'(idx); wire_val = v;
    tick();
    wire_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Pulse start and count edges until busy falls (bounded)
  task automatic run_eval(output int cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (busy && cnt < 5000);
  endtask

  initial begin
    rst = 1'b1; gate_we = 1'b0; gate_addr = '0; gate_op = 2'b11;
    gate_a = '0; gate_b = '0; gate_y = '0;
    wire_we = 1'b0; wire_idx = '0; wire_val = 1'b0; clear = 1'b0; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_sweeps", 32'(sweeps), 0);
    chk("rst_z", 32'(z_out), 0);

    // Single AND
    wr_gate(0, 2'b00, 0, 1, 48);
    prime(0, 1'b1); prime(1, 1'b1);
    for (int i = 49; i <= 55; i++) prime(i, 1'b0);
    run_eval(n);
    chk("and_cycles", 32'(n), 65);
    chk("and_done", 32'(done), 1);
    chk("and_error", 32'(error), 0);
    chk("and_z", 32'(z_out), 32'h01);
    chk("and_sweeps", 32'(sweeps), 2);

    // Reverse-order chain needs an extra sweep
    do_clear();
    wr_gate(0, 2'b01, 40, 40, 48);
    wr_gate(1, 2'b00, 0, 1, 40);
    prime(0, 1'b1); prime(1, 1'b1);
    for (int i = 49; i <= 55; i++) prime(i, 1'b0);
    run_eval(n);
    chk("chain_cycles", 32'(n), 97);
    chk("chain_done", 32'(done), 1);
    chk("chain_z", 32'(z_out), 32'h01);
    chk("chain_sweeps", 32'(sweeps), 3);

    // XOR byte: 0xA5 ^ 0x3C = 0x99
    do_clear();
    for (int i = 0; i < 8; i++) wr_gate(i, 2'b10, i, 8 + i, 48 + i);
    begin
      logic [7:0] xv, yv;
      xv = 8'hA5; yv = 8'h3C;
      for (int i = 0; i < 8; i++) begin
        prime(i, xv[i]);
        prime(8 + i, yv[i]);
      end
    end
    run_eval(n);
    chk("xor_cycles", 32'(n), 65);
    chk("xor_done", 32'(done), 1);
    chk("xor_z", 32'(z_out), 32'h99);
    chk("xor_sweeps", 32'(sweeps), 2);

    // Unresolvable: w55 never known
    do_clear();
    wr_gate(0, 2'b00, 0, 1, 48);
    for (int i = 1; i < 8; i++) wr_gate(i, 2'b11, 0, 0, 0);
    prime(0, 1'b1); prime(1, 1'b1);
    for (int i = 49; i <= 54; i++) prime(i, 1'b0);
    run_eval(n);
    chk("unres_error", 32'(error), 1);
    chk("unres_done", 32'(done), 0);
    chk("unres_z", 32'(z_out), 0);
    chk("unres_sweeps", 32'(sweeps), 2);
    do_clear();
    chk("unres_clear_error", 32'(error), 0);

    // Busy guards: writes, start and clear during EVAL are ignored
    prime(0, 1'b1); prime(1, 1'b1);
    for (int i = 49; i <= 55; i++) prime(i, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    repeat (3) begin tick(); n++; end
    gate_we = 1'b1; gate_addr = 5'd0; gate_op = 2'b10;
    gate_a = 6'd0; gate_b = 6'd1; gate_y = 6'd48;
    wire_we = 1'b1; wire_idx = 6'd48; wire_val = 1'b0;
    start = 1'b1; clear = 1'b1;
    tick(); n++;
    gate_we = 1'b0; wire_we = 1'b0; start = 1'b0; clear = 1'b0;
    do begin
      tick();
      n++;
    end while (busy && n < 5000);
    chk("guard_cycles", 32'(n), 65);
    chk("guard_done", 32'(done), 1);
    chk("guard_z", 32'(z_out), 32'h01);
    chk("guard_sweeps", 32'(sweeps), 2);

    // clear + start together in IDLE: clear wins
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("cs_busy", 32'(busy), 0);
    chk("cs_done", 32'(done), 0);
    run_eval(n);
    chk("cs_error", 32'(error), 1);
    chk("cs_sweeps", 32'(sweeps), 1);

    // Reset mid-EVAL
    prime(0, 1'b1); prime(1, 1'b1);
    for (int i = 49; i <= 55; i++) prime(i, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_error", 32'(error), 0);
    chk("mid_sweeps", 32'(sweeps), 0);
    chk("mid_z", 32'(z_out), 0);
    run_eval(n);
    chk("post_cycles", 32'(n), 33);
    chk("post_error", 32'(error), 1);
    chk("post_done", 32'(done), 0);
    chk("post_sweeps", 32'(sweeps), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/day24_gate_sched.md
Name: day24_gate_sched

Overview:
Sequencer for the AoC 2024 day-24 gate-network evaluator. It holds a programmable table of 2-input gates (AND/OR/XOR) and a wire value/known store. It sweeps the gate table one gate per cycle, firing every gate whose inputs are resolved, until a full sweep makes no progress. It then reports the z-wire result word, or an unresolved error. It sits between the top-level byte/IO front end, which loads gates and primes x/y wires, and the result output mux.

Parameters:
NUM_WIRES, 64, number of wires in the value/known store
WIRE_W, 6, wire index width (clog2 NUM_WIRES)
NUM_GATES, 32, gate table depth
GATE_W, 5, gate index width (clog2 NUM_GATES)
Z_BASE, 48, wire index of z00 (result LSB)
Z_BITS, 8, result width; wires Z_BASE..Z_BASE+Z_BITS-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
gate_we  in  1  write gate entry (IDLE only)
gate_addr  in  GATE_W  gate entry index
gate_op  in  2  00 AND, 01 OR, 10 XOR, 11 disabled
gate_a  in  WIRE_W  input wire A
gate_b  in  WIRE_W  input wire B
gate_y  in  WIRE_W  output wire
wire_we  in  1  prime wire (IDLE only): val<=wire_val, known<=1
wire_idx  in  WIRE_W  wire to prime
wire_val  in  1  primed value
clear  in  1  clear all known bits, done, error (IDLE only)
start  in  1  begin evaluation (IDLE only)
busy  out  1  high while sweeping
done  out  1  sticky: evaluation resolved all z wires
error  out  1  sticky: fixed point reached with some z wire unknown
sweeps  out  8  sweeps run in last evaluation, saturates at 255
z_out  out  Z_BITS  result word, bit i = value of wire Z_BASE+i

Behaviour:
- Reset: FSM=IDLE, busy=0, done=0, error=0, sweeps=0, z_out=0. All known bits=0. All gate ops=11. Other gate fields and wire values are don't-care. Reset mid-sweep aborts immediately with the same result.
- States: IDLE, EVAL, FINISH.
- IDLE: gate_we, wire_we and clear take effect on the clock edge. gate_we and wire_we may coincide with each other and with start; the writes land before the first evaluation.
- clear and start in the same cycle: clear wins, start is ignored.
- Accepting start: done=0, error=0, z_out=0, sweeps=0, gate idx g=0, progress=0; go to EVAL.
- All writes, clear and start are ignored while busy=1.
- EVAL: one gate per cycle, g=0..NUM_GATES-1. A gate fires if op!=11, known[a], known[b] and !known[y].
  - On fire: val[y]<=f(val[a],val[b]), known[y]<=1, progress<=1.
  - Updates are visible to every later gate, including later gates in the same sweep.
- Multiple drivers of one wire: the first to fire wins. A gate whose y is already known (primed or driven) never fires. A gate with y==a or y==b never fires.
- End of sweep (g==NUM_GATES-1): sweeps<=sat(sweeps+1). If progress, including a fire in this cycle, then g<=0, progress<=0 and stay in EVAL. Otherwise go to FINISH.
- FINISH (one cycle):
  - All z wires known: done<=1, z_out<=z values.
  - Otherwise: error<=1 and z_out stays 0.
  - Then go to IDLE.
- busy=1 in EVAL and FINISH. done/error become visible the cycle busy falls.
- Latency: start sampled at edge k. With S sweeps, done/error are high after edge k+S*NUM_GATES+1. The minimum is S=1.
- Known bits persist across evaluations until clear or rst. A re-start with no clear re-reports the same result with sweeps=1.
- Gate entries are kept across clear.

Test Plan:
- Single AND: prime w0=1, w1=1, w49..w55=0; gate0=AND(0,1)->48; others disabled. Start -> after 2*32+1 cycles done=1, error=0, z_out=0x01, sweeps=2.
- Reverse-order chain: gate0=OR(40,40)->48, gate1=AND(0,1)->40, w0=w1=1, w49..55 primed 0 -> gate0 resolves only in sweep 2; z_out=0x01, sweeps=3, done after 97 cycles.
- XOR byte: w0..7=x=0xA5, w8..15=y=0x3C, gates i=0..7 XOR(i,8+i)->48+i -> z_out=0x99, sweeps=2.
- Unresolvable: as the single-AND case but w55 not primed -> error=1, done=0, z_out=0, sweeps=2; clear -> error=0.
- Busy guards: during EVAL pulse gate_we, wire_we, start and clear -> no effect on result (z_out as without them). In IDLE, clear+start same cycle -> busy stays 0, known bits cleared.
- Reset mid-EVAL: assert rst at g=10 of sweep 1 -> next cycle busy=0, outputs 0. Start with no priming -> error=1, sweeps=1, done after 33 cycles.
